mfp_seven_segment_display_controller: RTL and testbench

Parametrised N-digit seven-segment controller for the board top levels. It replaces the per-digit static decoders with a single block that does the following:
- latches display data on a load strobe;
- decodes hex digits;
- applies per-digit enable, blinking and leading-zero blanking;
- drives both static (one segment bus per digit) and time-multiplexed (shared segment bus plus anodes) outputs.

It sits between the `IO_7_SegmentHEX` register output of `mfp_system` and the board `HEX*` / GPIO pins.

---
 rtl/mfp_seven_segment_pkg.sv | 48 ++++
 rtl/mfp_seven_segment_decoder.sv | 19 +
 rtl/mfp_seven_segment_display_controller.sv | 194 +++++++++++++++++++
 tb/tb_mfp_seven_segment_display_controller.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_seven_segment_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mfp_seven_segment_pkg
//  Description : Shared constants and hex-to-segment decode for the
//                seven-segment display controller. Patterns are active-low,
//                bit 0 = segment a ... bit 6 = segment g.
//  Revision    : 1.0 - initial release
// ============================================================================
package mfp_seven_segment_pkg;

   // Segment bit positions inside a 7-bit pattern
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam int SEG_W = SEG_G + 1;

   // All segments dark (active-low)
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] value);
      logic [SEG_W-1:0] seg;
      case (value)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;   // F
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_seven_segment_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_seven_segment_decoder
//  Description : Combinational 4-bit hex value to 7-bit active-low pattern.
//  Ports       : value - hex digit in
//                seg   - active-low segments out (bit 0 = a ... bit 6 = g)
//  Revision    : 1.0 - initial release
// ============================================================================
module mfp_seven_segment_decoder
   import mfp_seven_segment_pkg::*;
(
   input  logic [3:0]       value,
   output logic [SEG_W-1:0] seg
);

   assign seg = hex_to_seg(value);

endmodule
`default_nettype wire

// File: rtl/mfp_seven_segment_display_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mfp_seven_segment_display_controller
//  Description : N-digit seven-segment controller. Captures display data on
//                a load strobe into shadow registers, decodes hex digits,
//                applies enable / blink / leading-zero blanking and drives
//                both static per-digit and time-multiplexed outputs. All
//                outputs are registered and active-low.
//  Ports       : clk, resetn (async assert, active-low)
//                load, hex_in, dp_in, digit_en, blink_en, lz_blank - data in
//                seg_static, dp_static              - static outputs
//                seg_mux, dp_mux, an_mux            - multiplexed outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module mfp_seven_segment_display_controller
   import mfp_seven_segment_pkg::*;
#(
   parameter int N_DIGITS  = 8,
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
)(
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      load,
   input  logic [4*N_DIGITS-1:0]     hex_in,
   input  logic [N_DIGITS-1:0]       dp_in,
   input  logic [N_DIGITS-1:0]       digit_en,
   input  logic [N_DIGITS-1:0]       blink_en,
   input  logic                      lz_blank,
   output logic [SEG_W*N_DIGITS-1:0] seg_static,
   output logic [N_DIGITS-1:0]       dp_static,
   output logic [SEG_W-1:0]          seg_mux,
   output logic                      dp_mux,
   output logic [N_DIGITS-1:0]       an_mux
);

   localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int IDX_W   = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);

   // ---------------------------------------------------------------------
   // Shadow registers
   // ---------------------------------------------------------------------
   logic [4*N_DIGITS-1:0] sh_hex;
   logic [N_DIGITS-1:0]   sh_dp;
   logic [N_DIGITS-1:0]   sh_en;
   logic [N_DIGITS-1:0]   sh_blink;
   logic                  sh_lz;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh_hex   <= '0;
         sh_dp    <= '0;
         sh_en    <= '0;
         sh_blink <= '0;
         sh_lz    <= 1'b0;
      end else if (load) begin
         sh_hex   <= hex_in;
         sh_dp    <= dp_in;
         sh_en    <= digit_en;
         sh_blink <= blink_en;
         sh_lz    <= lz_blank;
      end
   end

   // ---------------------------------------------------------------------
   // Blink and scan timebases
   // ---------------------------------------------------------------------
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [IDX_W-1:0]   scan_idx;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Static-path decoders
   // ---------------------------------------------------------------------
   logic [SEG_W*N_DIGITS-1:0] dec_static;

   generate
      for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
         mfp_seven_segment_decoder u_dec (
            .value (sh_hex[4*g +: 4]),
            .seg   (dec_static[SEG_W*g +: SEG_W])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Blanking. zero_from[i] is the MSB-down AND chain "digits i..N-1 are
   // all zero", taken as a reduction over the upper slice of the shadow.
   // Digit 0 is excluded from leading-zero blanking so a zero value still
   // shows a single 0.
   // ---------------------------------------------------------------------
   logic [N_DIGITS-1:0]       zero_from;
   logic [N_DIGITS-1:0]       blank;
   logic [SEG_W*N_DIGITS-1:0] seg_proc;
   logic [N_DIGITS-1:0]       dp_proc;

   always_comb begin
      zero_from = '0;
      blank     = '0;
      seg_proc  = '1;
      dp_proc   = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         zero_from[i] = ~|(sh_hex >> (4 * i));
         blank[i]     = ~sh_en[i]
                      | (sh_blink[i] & blink_phase)
                      | (sh_lz & (i > 0) & zero_from[i]);
         seg_proc[SEG_W*i +: SEG_W] = blank[i] ? SEG_BLANK
                                              : dec_static[SEG_W*i +: SEG_W];
         dp_proc[i]   = blank[i] | ~sh_dp[i];
      end
   end

   // ---------------------------------------------------------------------
   // Multiplexed path: select the active digit, decode it, build anodes.
   // Anodes stay dark for the first cycle of every slot so the previous
   // digit's segments never appear on the next anode.
   // ---------------------------------------------------------------------
   logic [3:0]          mux_value;
   logic                mux_blank;
   logic                mux_dp_req;
   logic [SEG_W-1:0]    mux_dec;
   logic [N_DIGITS-1:0] an_next;

   always_comb begin
      mux_value  = '0;
      mux_blank  = 1'b1;
      mux_dp_req = 1'b0;
      an_next    = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (scan_idx == IDX_W'(i)) begin
            mux_value  = sh_hex[4*i +: 4];
            mux_blank  = blank[i];
            mux_dp_req = sh_dp[i];
            an_next[i] = (scan_cnt == '0);
         end
      end
   end

   mfp_seven_segment_decoder u_dec_mux (
      .value (mux_value),
      .seg   (mux_dec)
   );

   // ---------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         seg_static <= '1;
         dp_static  <= '1;
         seg_mux    <= '1;
         dp_mux     <= 1'b1;
         an_mux     <= '1;
      end else begin
         seg_static <= seg_proc;
         dp_static  <= dp_proc;
         seg_mux    <= mux_blank ? SEG_BLANK : mux_dec;
         dp_mux     <= mux_blank | ~mux_dp_req;
         an_mux     <= an_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mfp_seven_segment_display_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mfp_seven_segment_display_controller
//  Description : Self-checking bench for the seven-segment controller with
//                N_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8. Expected outputs come
//                from a reference model that derives scan / blink state from
//                the number of clock edges since reset and applies the
//                display rules digit by digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mfp_seven_segment_display_controller;

   localparam int ND    = 4;
   localparam int SDIV  = 4;
   localparam int BDIV  = 8;
   localparam int OBS_W = 7*ND + ND + 7 + 1 + ND;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              load = 1'b0;
   logic [4*ND-1:0]   hex_in = '0;
   logic [ND-1:0]     dp_in = '0;
   logic [ND-1:0]     digit_en = '0;
   logic [ND-1:0]     blink_en = '0;
   logic              lz_blank = 1'b0;
   logic [7*ND-1:0]   seg_static;
   logic [ND-1:0]     dp_static;
   logic [6:0]        seg_mux;
   logic              dp_mux;
   logic [ND-1:0]     an_mux;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mfp_seven_segment_display_controller #(
      .N_DIGITS  (ND),
      .SCAN_DIV  (SDIV),
      .BLINK_DIV (BDIV)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .load       (load),
      .hex_in     (hex_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .blink_en   (blink_en),
      .lz_blank   (lz_blank),
      .seg_static (seg_static),
      .dp_static  (dp_static),
      .seg_mux    (seg_mux),
      .dp_mux     (dp_mux),
      .an_mux     (an_mux)
   );

   wire [OBS_W-1:0] obs = {seg_static, dp_static, seg_mux, dp_mux, an_mux};

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;  default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // {dp, seg} for digit i given shadow contents and edges elapsed k
   function automatic logic [7:0] ref_digit(input int i, input logic [15:0] hx,
                                            input logic [3:0] dp, input logic [3:0] en,
                                            input logic [3:0] bl, input logic lz,
                                            input int k);
      bit blank;
      bit allz;
      blank = (en[i] == 1'b0) || (bl[i] && ((k / BDIV) % 2 == 1));
      if (lz && i > 0) begin
         allz = 1'b1;
         for (int j = i; j < ND; j++)
            if (hx[4*j +: 4] != 4'h0) allz = 1'b0;
         if (allz) blank = 1'b1;
      end
      if (blank) return 8'hFF;
      return {~dp[i], ref_seg(hx[4*i +: 4])};
   endfunction

   function automatic logic [OBS_W-1:0] ref_outputs(input int k, input logic [15:0] hx,
                                                    input logic [3:0] dp, input logic [3:0] en,
                                                    input logic [3:0] bl, input logic lz);
      logic [27:0] s;
      logic [3:0]  d;
      logic [7:0]  t;
      logic [3:0]  an;
      int          idx;
      for (int i = 0; i < ND; i++) begin
         t = ref_digit(i, hx, dp, en, bl, lz, k);
         s[7*i +: 7] = t[6:0];
         d[i] = t[7];
      end
      idx = (k / SDIV) % ND;
      t   = ref_digit(idx, hx, dp, en, bl, lz, k);
      an  = 4'hF;
      if (k % SDIV != 0) an[idx] = 1'b0;
      return {s, d, t[6:0], t[7], an};
   endfunction

   int              m_k;
   logic [15:0]     m_hex;
   logic [3:0]      m_dp, m_en, m_bl;
   logic            m_lz;
   logic [OBS_W-1:0] exp_o;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_k   <= 0;
         m_hex <= '0;
         m_dp  <= '0;
         m_en  <= '0;
         m_bl  <= '0;
         m_lz  <= 1'b0;
         exp_o <= '1;
      end else begin
         exp_o <= ref_outputs(m_k, m_hex, m_dp, m_en, m_bl, m_lz);
         m_k   <= m_k + 1;
         if (load) begin
            m_hex <= hex_in;
            m_dp  <= dp_in;
            m_en  <= digit_en;
            m_bl  <= blink_en;
            m_lz  <= lz_blank;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset();
      resetn = 1'b0;
      load   = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== '1) $display("FAIL reset_hold: got %h expected all ones", obs);
         else passed++;
      end
      resetn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_o) $display("FAIL reset_model: got %h expected %h", obs, exp_o);
         else passed++;
         checks++;
         if (seg_static !== '1 || dp_static !== '1)
            $display("FAIL reset_blank: got %h/%h expected all ones", seg_static, dp_static);
         else passed++;
         checks++;
         if (an_mux !== 4'hF && seg_mux !== 7'h7F)
            $display("FAIL reset_anode: got an=%b seg=%b expected dark segments", an_mux, seg_mux);
         else passed++;
      end
   endtask

   task automatic test_basic();
      int lows;
      int idx;
      @(negedge clk);
      hex_in = 16'h12AF; digit_en = 4'hF; dp_in = 4'b0001;
      blink_en = 4'h0; lz_blank = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      checks++;
      if (seg_static[6:0] !== 7'b0001110)
         $display("FAIL basic_digit0: got %b expected 0001110", seg_static[6:0]);
      else passed++;
      checks++;
      if (dp_static !== 4'b1110) $display("FAIL basic_dp: got %b expected 1110", dp_static);
      else passed++;
      lows = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_o) $display("FAIL basic_model: got %h expected %h", obs, exp_o);
         else passed++;
         if (an_mux !== 4'hF) begin
            lows++;
            idx = 0;
            for (int i = 0; i < ND; i++) if (an_mux[i] == 1'b0) idx = i;
            checks++;
            if (seg_mux !== seg_static[7*idx +: 7])
               $display("FAIL basic_mux_seg: got %b expected %b", seg_mux, seg_static[7*idx +: 7]);
            else passed++;
         end
      end
      checks++;
      if (lows != 12) $display("FAIL basic_anode_duty: got %0d expected 12", lows);
      else passed++;
   endtask

   task automatic test_lz();
      @(negedge clk);
      hex_in = 16'h0040; digit_en = 4'hF; dp_in = 4'h0;
      blink_en = 4'h0; lz_blank = 1'b1; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      checks++;
      if (seg_static !== {7'h7F, 7'h7F, 7'b0011001, 7'b1000000})
         $display("FAIL lz_0040: got %h expected %h", seg_static,
                  {7'h7F, 7'h7F, 7'b0011001, 7'b1000000});
      else passed++;
      hex_in = 16'h0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      checks++;
      if (seg_static !== {7'h7F, 7'h7F, 7'h7F, 7'b1000000})
         $display("FAIL lz_0000: got %h expected %h", seg_static,
                  {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
      else passed++;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_o) $display("FAIL lz_model: got %h expected %h", obs, exp_o);
         else passed++;
      end
   endtask

   task automatic test_blink();
      int toggles;
      logic [6:0] prev;
      @(negedge clk);
      hex_in = 16'h8888; digit_en = 4'hF; dp_in = 4'h0;
      blink_en = 4'b0100; lz_blank = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      prev = seg_static[20:14];
      toggles = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_o) $display("FAIL blink_model: got %h expected %h", obs, exp_o);
         else passed++;
         checks++;
         if (seg_static[6:0] !== 7'h00 || seg_static[13:7] !== 7'h00 || seg_static[27:21] !== 7'h00)
            $display("FAIL blink_steady: got %h expected other digits 8", seg_static);
         else passed++;
         if (seg_static[20:14] !== prev) toggles++;
         prev = seg_static[20:14];
      end
      checks++;
      if (toggles < 4 || toggles > 5) $display("FAIL blink_toggles: got %0d expected 4..5", toggles);
      else passed++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_o) $display("FAIL random_model: got %h expected %h", obs, exp_o);
         else passed++;
         hex_in   = 16'($urandom) >> (4 * $urandom_range(0, 4));
         dp_in    = 4'($urandom);
         digit_en = 4'($urandom) | 4'($urandom);
         blink_en = 4'($urandom) & 4'($urandom);
         lz_blank = 1'($urandom);
         load     = (c >= 60 && c < 72) ? 1'b1 : ($urandom_range(0, 4) == 0);
      end
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit found;
      bit seen_low;
      found = 1'b0;
      for (int c = 0; c < 64 && !found; c++) begin
         @(negedge clk);
         if (m_k % SDIV == 1 && (m_k / SDIV) % ND == 2) found = 1'b1;
      end
      checks++;
      if (!found) $display("FAIL midreset_wait: got timeout expected scan slot 2 count 1");
      else passed++;
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (obs !== '1) $display("FAIL midreset_async: got %h expected all ones", obs);
      else passed++;
      hex_in = 16'h1234; digit_en = 4'hF; load = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== '1) $display("FAIL midreset_hold: got %h expected all ones", obs);
         else passed++;
      end
      load = 1'b0;
      resetn = 1'b1;
      seen_low = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_o) $display("FAIL midreset_model: got %h expected %h", obs, exp_o);
         else passed++;
         checks++;
         if (seg_static !== '1) $display("FAIL midreset_blank: got %h expected all ones", seg_static);
         else passed++;
         if (!seen_low && an_mux !== 4'hF) begin
            seen_low = 1'b1;
            checks++;
            if (an_mux !== 4'b1110) $display("FAIL midreset_first_anode: got %b expected 1110", an_mux);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lz();
      test_blink();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
